seg_display_driver: RTL and testbench

SEG_DISPLAY_DRIVER -- requirements
Module: seg_display_driver

---
 rtl/seg_display_driver_pkg.sv | 20 ++
 rtl/seg_display_driver_seg7_decode.sv | 9 +
 rtl/seg_display_driver.sv | 100 ++++++++++
 tb/tb_seg_display_driver.sv | 132 +++++++++++++
 4 files changed

// File: rtl/seg_display_driver_pkg.sv
// seg_display_driver_pkg: FSM encoding, segment patterns and BCD helper for the display driver
package seg_display_driver_pkg;
  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] SHIFT  = 2'd1;
  localparam logic [1:0] COMMIT = 2'd2;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_DASH  = 7'b0111111;
  localparam logic [9:0][6:0] SEG_DIGITS = {
    7'b0010000, 7'b0000000, 7'b1111000, 7'b0000010, 7'b0010010,
    7'b0011001, 7'b0110000, 7'b0100100, 7'b1111001, 7'b1000000
  };
  localparam logic [31:0] MAX_DISP = 32'd9999;
  localparam logic [3:0]  LAST_BIT = 4'd13;
  function automatic logic [15:0] bcd_adjust(input logic [15:0] b);
    logic [15:0] r;
    for (int i = 0; i < 4; i++)
      r[4*i+:4] = (b[4*i+:4] >= 4'd5) ? b[4*i+:4] + 4'd3 : b[4*i+:4];
    return r;
  endfunction
endpackage

// File: rtl/seg_display_driver_seg7_decode.sv
// seg7_decode: active-low {g..a} pattern for a BCD digit; non-decimal codes go blank
module seg7_decode
  import seg_display_driver_pkg::*;
(
  input  logic [3:0] digit,
  output logic [6:0] seg
);
  assign seg = (digit <= 4'd9) ? SEG_DIGITS[digit] : SEG_BLANK;
endmodule

// File: rtl/seg_display_driver.sv
// seg_display_driver: converts a 32-bit value to BCD by double-dabble and scans it onto a
// 4-digit multiplexed 7-segment display, showing dashes when the value exceeds 9999
module seg_display_driver
  import seg_display_driver_pkg::*;
#(
  parameter int REFRESH_DIV = 100000,
  parameter bit BLANK_LZ    = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] disp_data,
  output logic [3:0]  an,
  output logic [6:0]  seg,
  output logic        dp,
  output logic        busy
);
  localparam int RW = $clog2(REFRESH_DIV);
  localparam logic [RW-1:0] REF_LAST = RW'(REFRESH_DIV - 1);
  logic [1:0]    state_q, state_d;
  logic [3:0]    cnt_q, cnt_d;
  logic [31:0]   cap_q, cap_d, last_q, last_d;
  logic [13:0]   sh_q, sh_d;
  logic [15:0]   bcd_q, bcd_d, dig_q, dig_d, adj;
  logic          ovf_q, ovf_d;
  logic [RW-1:0] ref_q, ref_d;
  logic [1:0]    sel_q, sel_d;
  logic [6:0]    seg_q, seg_d, dec_seg;
  logic [3:0]    cur_digit;
  logic          lead_zero;
  // cap_q stays intact for last_val/ovf while sh_q is consumed by the shifter
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    cap_d   = cap_q;
    last_d  = last_q;
    sh_d    = sh_q;
    bcd_d   = bcd_q;
    dig_d   = dig_q;
    ovf_d   = ovf_q;
    adj     = bcd_adjust(bcd_q);
    case (state_q)
      IDLE: if (disp_data != last_q) begin
        cap_d   = disp_data;
        sh_d    = disp_data[13:0];
        bcd_d   = '0;
        cnt_d   = '0;
        state_d = SHIFT;
      end
      SHIFT: begin
        {bcd_d, sh_d} = {adj, sh_q} << 1;
        cnt_d   = cnt_q + 4'd1;
        state_d = (cnt_q == LAST_BIT) ? COMMIT : SHIFT;
      end
      COMMIT: begin
        dig_d   = bcd_q;
        ovf_d   = cap_q > MAX_DISP;
        last_d  = cap_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end
  assign ref_d     = (ref_q == REF_LAST) ? '0 : ref_q + RW'(1);
  assign sel_d     = (ref_q == REF_LAST) ? sel_q + 2'd1 : sel_q;
  assign cur_digit = dig_q[{sel_d, 2'b00} +: 4];
  assign lead_zero = BLANK_LZ && sel_d != 2'd0 && (dig_q >> {sel_d, 2'b00}) == 16'd0;
  assign seg_d     = ovf_q ? SEG_DASH : lead_zero ? SEG_BLANK : dec_seg;
  seg7_decode u_dec (.digit(cur_digit), .seg(dec_seg));
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      cap_q   <= '0;
      last_q  <= '0;
      sh_q    <= '0;
      bcd_q   <= '0;
      dig_q   <= '0;
      ovf_q   <= 1'b0;
      ref_q   <= '0;
      sel_q   <= '0;
      seg_q   <= SEG_DIGITS[0];
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      cap_q   <= cap_d;
      last_q  <= last_d;
      sh_q    <= sh_d;
      bcd_q   <= bcd_d;
      dig_q   <= dig_d;
      ovf_q   <= ovf_d;
      ref_q   <= ref_d;
      sel_q   <= sel_d;
      seg_q   <= seg_d;
    end
  end
  assign an   = ~(4'b0001 << sel_q);
  assign seg  = seg_q;
  assign dp   = 1'b1;
  assign busy = state_q != IDLE;
endmodule

// File: tb/tb_seg_display_driver.sv
// tb_seg_display_driver: scoreboarded check of conversion, blanking, overflow and scanning
module tb_seg_display_driver;
  localparam int DIV = 4;
  localparam logic [6:0] S0 = 7'b1000000, S1 = 7'b1111001, S2 = 7'b0100100, S3 = 7'b0110000;
  localparam logic [6:0] S4 = 7'b0011001, S6 = 7'b0000010, S9 = 7'b0010000;
  localparam logic [6:0] SB = 7'b1111111, SD = 7'b0111111;
  logic clk = 1'b0, reset = 1'b1;
  logic [31:0] disp_data = '0;
  logic [3:0] an;
  logic [6:0] seg;
  logic dp, busy;
  int vectors = 0, miscompares = 0, done_cnt = 0, run = 0, seen = 0, pushes = 0, scans_done = 0;
  logic [27:0] exp_q[$];
  logic [27:0] e;
  logic [6:0] got[4];
  logic [3:0] ea;

  seg_display_driver #(.REFRESH_DIV(DIV), .BLANK_LZ(1'b1)) dut (
    .clk(clk), .reset(reset), .disp_data(disp_data),
    .an(an), .seg(seg), .dp(dp), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic apply(input logic [31:0] val, input logic [27:0] exp);
    @(posedge clk);
    #1;
    exp_q.push_back(exp);
    pushes++;
    disp_data = val;
    repeat (40) @(posedge clk);
  endtask

  // busy run-length checker; a run cut short by reset is discarded
  initial forever begin
    @(negedge clk);
    if (reset) run = 0;
    else if (busy) run++;
    else if (run > 0) begin
      chk("busy_len", run, 15);
      run = 0;
      done_cnt++;
    end
  end

  // after each commit, scan all four digits and compare with the next expectation
  initial forever begin
    wait (done_cnt > seen);
    seen++;
    if (exp_q.size() == 0) chk("unexpected_commit", exp_q.size(), 1);
    else begin
      e = exp_q.pop_front();
      got = '{default: 7'h55};
      for (int i = 0; i < 4 * DIV; i++) begin
        @(negedge clk);
        case (an)
          4'b1110: got[0] = seg;
          4'b1101: got[1] = seg;
          4'b1011: got[2] = seg;
          4'b0111: got[3] = seg;
          default: chk("an_onehot", an, 4'b1110);
        endcase
      end
      for (int k = 0; k < 4; k++) chk($sformatf("digit%0d", k), got[k], e[7*k+:7]);
      scans_done++;
    end
  end

  initial begin
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    for (int i = 0; i < 17; i++) begin
      @(negedge clk);
      ea = ~(4'b0001 << ((i / 4) % 4));
      chk("scan_an", an, ea);
      chk("scan_seg", seg, ((i / 4) % 4) == 0 ? S0 : SB);
      if (i == 0) begin
        chk("reset_busy", busy, 0);
        chk("reset_dp", dp, 1);
      end
    end
    apply(1, {SB, SB, SB, S1});
    apply(2, {SB, SB, SB, S2});
    apply(6, {SB, SB, SB, S6});
    apply(24, {SB, SB, S2, S4});
    apply(9999, {S9, S9, S9, S9});
    apply(10000, {SD, SD, SD, SD});
    apply(0, {SB, SB, SB, S0});
    apply(32'h0001_0005, {SD, SD, SD, SD});
    @(posedge clk);
    #1;
    exp_q.push_back({SB, SB, SB, S6});
    exp_q.push_back({SB, SB, S2, S4});
    pushes += 2;
    disp_data = 6;
    repeat (3) @(posedge clk);
    #1;
    chk("busy_in_shift", busy, 1);
    disp_data = 24;
    repeat (60) @(posedge clk);
    #1;
    exp_q.push_back({S1, S2, S3, S4});
    pushes++;
    disp_data = 1234;
    repeat (7) @(posedge clk);
    #1;
    chk("busy_before_reset", busy, 1);
    reset = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_mid_an", an, 4'b1110);
    chk("rst_mid_seg", seg, S0);
    chk("rst_mid_busy", busy, 0);
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("post_rst_an", an, 4'b1110);
    chk("post_rst_seg", seg, S0);
    for (int i = 0; i < 200 && scans_done != pushes; i++) @(posedge clk);
    chk("all_scanned", scans_done, pushes);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
